// File: rtl/lsu_pkg.sv
// lsu_pkg: op codes, FSM state encoding and op classification helpers
// shared by the load/store unit and its lane-steering block.
package lsu_pkg;

   localparam logic [7:0] EXE_LB_OP  = 8'h20;
   localparam logic [7:0] EXE_LH_OP  = 8'h21;
   localparam logic [7:0] EXE_LW_OP  = 8'h23;
   localparam logic [7:0] EXE_LBU_OP = 8'h24;
   localparam logic [7:0] EXE_LHU_OP = 8'h25;
   localparam logic [7:0] EXE_SB_OP  = 8'h28;
   localparam logic [7:0] EXE_SH_OP  = 8'h29;
   localparam logic [7:0] EXE_SW_OP  = 8'h2b;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } lsu_state_t;

   function automatic logic op_is_load(input logic [7:0] op);
      case (op)
         EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP,
         EXE_LHU_OP, EXE_LW_OP: return 1'b1;
         default:              return 1'b0;
      endcase
   endfunction

   function automatic logic op_is_store(input logic [7:0] op);
      case (op)
         EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: return 1'b1;
         default:                         return 1'b0;
      endcase
   endfunction

   function automatic logic op_misaligned(input logic [7:0] op,
                                          input logic [1:0] lo);
      case (op)
         EXE_LW_OP, EXE_SW_OP:             return lo != 2'b00;
         EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return lo[0];
         default:                          return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: little-endian store lane steering and load byte/half
// selection with sign or zero extension.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [7:0]  op,
   input  logic [1:0]  lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  we,
   output logic [31:0] st_data,
   output logic [31:0] ld_data
);

   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      we      = 4'b0000;
      st_data = '0;
      case (op)
         EXE_SB_OP: begin
            we      = 4'b0001 << lo;
            st_data = {4{wdata[7:0]}};
         end
         EXE_SH_OP: begin
            we      = lo[1] ? 4'b1100 : 4'b0011;
            st_data = {2{wdata[15:0]}};
         end
         EXE_SW_OP: begin
            we      = 4'b1111;
            st_data = wdata;
         end
         default: ;
      endcase
   end

   always_comb begin
      b = rdata[7:0];
      case (lo)
         2'd1:    b = rdata[15:8];
         2'd2:    b = rdata[23:16];
         2'd3:    b = rdata[31:24];
         default: b = rdata[7:0];
      endcase
      h       = lo[1] ? rdata[31:16] : rdata[15:0];
      ld_data = rdata;
      case (op)
         EXE_LB_OP:  ld_data = {{24{b[7]}}, b};
         EXE_LBU_OP: ld_data = {24'b0, b};
         EXE_LH_OP:  ld_data = {{16{h[15]}}, h};
         EXE_LHU_OP: ld_data = {16'b0, h};
         default:    ld_data = rdata;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit, IDLE/BUSY/RESP handshake to data memory.
// Define LSU_TIMEOUT_EN to abort BUSY after TIMEOUT_CYCLES with bus_err.
module lsu
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [7:0]  op,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        adel,
   output logic        ades,
   output logic        bus_err,
   output logic [31:0] badvaddr,
   output logic        stall,
   output logic        dm_en,
   output logic [3:0]  dm_we,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   input  logic        dm_ack,
   input  logic [31:0] dm_rdata
);

   lsu_state_t  state, state_n;
   logic [7:0]  op_q;
   logic [31:0] addr_q, wdata_q, rdata_q;
   logic        adel_q, ades_q, berr_q;
   logic        accept, mis, known, busy, resp, tmo;
   logic [3:0]  we;
   logic [31:0] st_data, ld_data;

   assign accept = req_valid && (state == IDLE);
   assign mis    = op_misaligned(op, addr[1:0]);
   assign known  = op_is_load(op) || op_is_store(op);
   assign busy   = (state == BUSY);
   assign resp   = (state == RESP);

`ifdef LSU_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)        cnt <= '0;
      else if (!busy) cnt <= '0;
      else            cnt <= cnt + CW'(1);
   end

   assign tmo     = busy && !dm_ack && (cnt == CW'(TIMEOUT_CYCLES - 1));
   assign bus_err = resp && berr_q;
`else
   logic unused_cfg;
   assign unused_cfg = (TIMEOUT_CYCLES == 0);
   assign tmo        = 1'b0;
   assign bus_err    = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (accept) state_n = (known && !mis) ? BUSY : RESP;
         BUSY:    if (dm_ack || tmo) state_n = RESP;
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         adel_q  <= 1'b0;
         ades_q  <= 1'b0;
         berr_q  <= 1'b0;
      end else if (accept) begin
         op_q    <= op;
         addr_q  <= addr;
         wdata_q <= wdata;
         rdata_q <= '0;
         adel_q  <= mis && op_is_load(op);
         ades_q  <= mis && op_is_store(op);
         berr_q  <= 1'b0;
      end else if (busy) begin
         if (dm_ack) rdata_q <= op_is_load(op_q) ? ld_data : '0;
         if (tmo)    berr_q  <= 1'b1;
      end
   end

   lsu_align u_align (
      .op      (op_q),
      .lo      (addr_q[1:0]),
      .wdata   (wdata_q),
      .rdata   (dm_rdata),
      .we      (we),
      .st_data (st_data),
      .ld_data (ld_data)
   );

   // Held low through rst even if upstream keeps req_valid asserted.
   assign stall      = !rst && (accept || (state != IDLE));
   assign req_ready  = (state == IDLE);
   assign dm_en      = busy;
   assign dm_addr    = busy ? {addr_q[31:2], 2'b00} : '0;
   assign dm_we      = busy ? we : 4'b0000;
   assign dm_wdata   = busy ? st_data : '0;
   assign resp_valid = resp;
   assign resp_rdata = resp ? rdata_q : '0;
   assign adel       = resp && adel_q;
   assign ades       = resp && ades_q;
   assign badvaddr   = (resp && (adel_q || ades_q || berr_q)) ? addr_q : '0;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed and random transactions against a transaction-level
// model of the load/store unit.
module tb_lsu;
   import lsu_pkg::*;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready;
   logic [7:0]  op;
   logic [31:0] addr, wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        adel, ades, bus_err;
   logic [31:0] badvaddr;
   logic        stall, dm_en;
   logic [3:0]  dm_we;
   logic [31:0] dm_addr, dm_wdata;
   logic        dm_ack;
   logic [31:0] dm_rdata;

   int n_assert = 0;
   int n_fail   = 0;
   logic [35:0] txq[$];

   always #5 clk = ~clk;

   lsu #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .op         (op),
      .addr       (addr),
      .wdata      (wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .adel       (adel),
      .ades       (ades),
      .bus_err    (bus_err),
      .badvaddr   (badvaddr),
      .stall      (stall),
      .dm_en      (dm_en),
      .dm_we      (dm_we),
      .dm_addr    (dm_addr),
      .dm_wdata   (dm_wdata),
      .dm_ack     (dm_ack),
      .dm_rdata   (dm_rdata)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_load(input logic [7:0] o);
      return o == EXE_LW_OP || o == EXE_LH_OP || o == EXE_LHU_OP ||
             o == EXE_LB_OP || o == EXE_LBU_OP;
   endfunction

   function automatic bit m_store(input logic [7:0] o);
      return o == EXE_SW_OP || o == EXE_SH_OP || o == EXE_SB_OP;
   endfunction

   function automatic bit m_mis(input logic [7:0] o, input logic [31:0] a);
      int r;
      r = int'(a % 32'd4);
      if (o == EXE_LW_OP || o == EXE_SW_OP) return r != 0;
      if (o == EXE_LH_OP || o == EXE_LHU_OP || o == EXE_SH_OP)
         return (r % 2) != 0;
      return 1'b0;
   endfunction

   function automatic logic [35:0] m_store_bus(input logic [7:0] o,
                                               input logic [31:0] a,
                                               input logic [31:0] w);
      int r;
      logic [3:0]  e_we;
      logic [31:0] e_wd;
      r    = int'(a % 32'd4);
      e_we = 4'h0;
      e_wd = 32'h0;
      if (o == EXE_SB_OP) begin
         e_we = 4'(1 << r);
         e_wd = {24'b0, w[7:0]} * 32'h0101_0101;
      end else if (o == EXE_SH_OP) begin
         e_we = (r >= 2) ? 4'hC : 4'h3;
         e_wd = {16'b0, w[15:0]} * 32'h0001_0001;
      end else if (o == EXE_SW_OP) begin
         e_we = 4'hF;
         e_wd = w;
      end
      return {e_we, e_wd};
   endfunction

   function automatic logic [31:0] m_load_data(input logic [7:0] o,
                                               input logic [31:0] a,
                                               input logic [31:0] rd);
      logic [31:0] v;
      v = rd >> (8 * (a % 32'd4));
      if (o == EXE_LB_OP)  return 32'($signed(v[7:0]));
      if (o == EXE_LBU_OP) return v & 32'hFF;
      if (o == EXE_LH_OP)  return 32'($signed(v[15:0]));
      if (o == EXE_LHU_OP) return v & 32'hFFFF;
      return rd;
   endfunction

   // waits < 0 means memory never acks (bus timeout expected).
   task automatic do_op(input logic [7:0] o, input logic [31:0] a,
                        input logic [31:0] wd, input int waits,
                        input logic [31:0] rd, input bit keep);
      bit ld, st, mis, bus, berr, got;
      int nbusy, cyc;
      logic [35:0] sb;
      logic [31:0] e_rd;
      ld    = m_load(o);
      st    = m_store(o);
      mis   = m_mis(o, a);
      bus   = (ld || st) && !mis;
      berr  = bus && (waits < 0);
      nbusy = berr ? TMO : waits + 1;
      sb    = m_store_bus(o, a, wd);
      e_rd  = (ld && bus && !berr) ? m_load_data(o, a, rd) : 32'h0;

      req_valid = 1'b1;
      op        = o;
      addr      = a;
      wdata     = wd;
      dm_ack    = 1'b0;
      #1;
      chk("accept_ready", req_ready, 1);
      chk("accept_stall", stall, 1);

      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 300) begin
         @(posedge clk);
         #1;
         dm_ack   = 1'b0;
         dm_rdata = $urandom;
         cyc++;
         if (resp_valid) begin
            got = 1'b1;
         end else begin
            chk("busy_dm_en", dm_en, 1);
            chk("busy_dm_addr", dm_addr, a & 32'hFFFF_FFFC);
            chk("busy_dm_we", dm_we, sb[35:32]);
            if (st) chk("busy_dm_wdata", dm_wdata, sb[31:0]);
            chk("busy_ready", req_ready, 0);
            chk("busy_stall", stall, 1);
            if (waits >= 0 && cyc == waits + 1) begin
               txq.push_back({dm_we, dm_addr});
               dm_ack   = 1'b1;
               dm_rdata = rd;
            end
         end
      end
      chk("resp_seen", got, 1);
      chk("latency", cyc, bus ? nbusy + 1 : 1);
      chk("resp_rdata", resp_rdata, e_rd);
      chk("resp_adel", adel, ld && mis);
      chk("resp_ades", ades, st && mis);
      chk("resp_bus_err", bus_err, berr);
      if (mis || berr) chk("resp_badvaddr", badvaddr, a);
      chk("resp_dm_en", dm_en, 0);
      chk("resp_stall", stall, 1);

      req_valid = keep;
      @(posedge clk);
      #1;
      chk("resp_once", resp_valid, 0);
      chk("post_ready", req_ready, 1);
      chk("post_stall", stall, keep);
      chk("post_adel", adel | ades | bus_err, 0);
      chk("post_rdata", resp_rdata, 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         dm_ack   = 1'($urandom_range(0, 1));
         dm_rdata = $urandom;
         @(posedge clk);
         #1;
         chk("idle_ready", req_ready, 1);
         chk("idle_resp", resp_valid, 0);
         chk("idle_dm_en", dm_en, 0);
         chk("idle_stall", stall, 0);
      end
      dm_ack = 1'b0;
   endtask

   initial begin
      logic [7:0] ops [9];
      ops = '{EXE_LW_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LB_OP, EXE_LBU_OP,
              EXE_SW_OP, EXE_SH_OP, EXE_SB_OP, 8'hFF};
      rst       = 1'b1;
      req_valid = 1'b0;
      op        = 8'h0;
      addr      = 32'h0;
      wdata     = 32'h0;
      dm_ack    = 1'b0;
      dm_rdata  = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", req_ready, 1);
      chk("rst_stall", stall, 0);
      chk("rst_dm", {dm_en, dm_we, dm_addr, dm_wdata}, 0);
      chk("rst_resp", {resp_valid, resp_rdata, adel, ades, bus_err}, 0);
      chk("rst_badvaddr", badvaddr, 0);
      rst = 1'b0;
      idle(2);

      do_op(EXE_SB_OP, 32'h1003, 32'h0000_00AB, 1, 32'h0, 0);
      do_op(EXE_LB_OP, 32'h2001, 32'h0, 0, 32'h0000_80FF, 0);
      do_op(EXE_LBU_OP, 32'h2001, 32'h0, 0, 32'h0000_80FF, 0);
      do_op(EXE_LW_OP, 32'h3002, 32'h0, 0, 32'h0, 0);
      do_op(EXE_SH_OP, 32'h3001, 32'h1234, 0, 32'h0, 0);
      do_op(EXE_SH_OP, 32'h3002, 32'hBEEF, 2, 32'h0, 0);
      do_op(EXE_LH_OP, 32'h3002, 32'h0, 0, 32'h8001_7FFF, 0);
      do_op(8'hFF, 32'h3000, 32'h0, 0, 32'h0, 0);
      idle(2);

      txq.delete();
      do_op(EXE_LW_OP, 32'h4000, 32'h0, 1, 32'hCAFE_F00D, 1);
      do_op(EXE_SW_OP, 32'h4010, 32'h5555_AAAA, 0, 32'h0, 0);
      chk("b2b_count", txq.size(), 2);
      if (txq.size() == 2) begin
         chk("b2b_first", txq[0], {4'h0, 32'h4000});
         chk("b2b_second", txq[1], {4'hF, 32'h4010});
      end

      req_valid = 1'b1;
      op        = EXE_SW_OP;
      addr      = 32'h5004;
      wdata     = 32'h1111_2222;
      @(posedge clk);
      #1;
      chk("mid_busy_en", dm_en, 1);
      rst       = 1'b1;
      req_valid = 1'b0;
      #1;
      chk("mid_rst_dm_en", dm_en, 0);
      chk("mid_rst_ready", req_ready, 1);
      chk("mid_rst_we", dm_we, 0);
      chk("mid_rst_stall", stall, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         chk("post_rst_resp", resp_valid, 0);
         chk("post_rst_dm_en", dm_en, 0);
      end

`ifdef LSU_TIMEOUT_EN
      do_op(EXE_LW_OP, 32'h6000, 32'h0, -1, 32'h0, 0);
`endif

      for (int i = 0; i < 40; i++) begin
         logic [7:0] o;
         bit         k;
         o = ops[$urandom_range(0, 8)];
         k = 1'($urandom_range(0, 1));
         do_op(o, $urandom, $urandom, $urandom_range(0, 3), $urandom, k);
         if (!k && $urandom_range(0, 1) == 1) idle(1);
      end
      req_valid = 1'b0;
      idle(1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, maximum cycles spent waiting for dm_ack (used only under LSU_TIMEOUT_EN).
REQ-002 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 req_valid  in  1  execute stage presents a memory op.
REQ-006 req_ready  out  1  LSU can accept an op; high only in IDLE.
REQ-007 op  in  8  EXE_LW/LH/LHU/LB/LBU/SW/SH/SB_OP code.
REQ-008 addr  in  32  effective address (ALU sum).
REQ-009 wdata  in  32  store data (rt).
REQ-010 resp_valid  out  1  one-cycle completion pulse.
REQ-011 resp_rdata  out  32  load result, aligned and extended.
REQ-012 adel / ades  out  1 each  load / store address error.
REQ-013 bus_err  out  1  bus timeout (0 when LSU_TIMEOUT_EN is absent).
REQ-014 badvaddr  out  32  faulting address; valid with adel/ades.
REQ-015 stall  out  1  pipeline hold; high from acceptance until resp_valid, inclusive.
REQ-016 dm_en  out  1  data-memory request.
REQ-017 dm_we  out  4  byte write enables; 0 for loads.
REQ-018 dm_addr  out  32  word address {addr[31:2],2'b00}.
REQ-019 dm_wdata  out  32  lane-replicated store data.
REQ-020 dm_ack  in  1  memory completion.
REQ-021 dm_rdata  in  32  memory read word, valid with dm_ack.

Function
REQ-022 FSM states: IDLE, BUSY, RESP; op, addr and wdata are registered on acceptance (req_valid && req_ready).
REQ-023 IDLE: on an aligned accept, go to BUSY with dm_en=1 in the next cycle.
REQ-024 IDLE: on a misaligned accept, go to RESP; no bus access occurs.
REQ-025 BUSY: dm_en, dm_addr, dm_we and dm_wdata are held stable until dm_ack.
REQ-026 BUSY: on dm_ack, capture dm_rdata and go to RESP.
REQ-027 RESP: resp_valid=1 for exactly one cycle, then go to IDLE.
REQ-028 Minimum latency is acceptance, then a dm_en cycle, with resp_valid one cycle after dm_ack; a zero-wait memory gives resp_valid 2 cycles after acceptance.
REQ-029 Misaligned means LW/SW with addr[1:0]!=0, or LH/LHU/SH with addr[0]!=0.
REQ-030 Misaligned loads set adel; misaligned stores set ades; badvaddr=addr; resp_rdata=0.
REQ-031 Store lanes are little-endian: SB gives dm_we=4'b0001<<addr[1:0] and dm_wdata={4{wdata[7:0]}}.
REQ-032 SH gives dm_we=addr[1]?4'b1100:4'b0011 and dm_wdata={2{wdata[15:0]}}.
REQ-033 SW gives dm_we=4'b1111 and dm_wdata=wdata.
REQ-034 Load byte/half is selected by addr[1:0]; LB/LH sign-extend and LBU/LHU zero-extend to 32 bits.
REQ-035 Outside RESP, resp_rdata, adel, ades, bus_err and badvaddr are 0.
REQ-036 req_valid while not in IDLE is ignored (req_ready=0); the op must be held upstream via stall.
REQ-037 dm_ack outside BUSY is ignored.
REQ-038 An unknown op code is treated as a no-op: no bus access, and RESP with all flags 0.

Reset
REQ-039 rst forces IDLE immediately, at any point including mid-BUSY, and the in-flight op is dropped.
REQ-040 During rst, all outputs are 0 except req_ready=1.

Configuration
REQ-041 With LSU_TIMEOUT_EN defined, a counter runs in BUSY; if TIMEOUT_CYCLES elapse without dm_ack, dm_en drops and RESP follows with bus_err=1, resp_rdata=0, badvaddr=addr.
REQ-042 With LSU_TIMEOUT_EN undefined, there is no counter, bus_err is tied to 0, and BUSY waits indefinitely.

Structure
REQ-043 EXE_*_OP codes and the FSM state encodings live in the shared defines file.
REQ-044 Lane steering and load extension live in a combinational sub-module, lsu_align.

Verification
REQ-045 SB with addr=0x1003 and wdata=0xAB, ack after 1 wait cycle -> dm_we=1000, dm_wdata=0xABABABAB, dm_addr=0x1000, resp_valid 3 cycles after acceptance.
REQ-046 LB with addr=0x2001 and dm_rdata=0x0000_80FF -> resp_rdata=0xFFFFFF80; the same access with LBU -> 0x00000080.
REQ-047 LW with addr=0x3002 -> adel=1, badvaddr=0x3002, dm_en never asserted, resp_valid the next cycle; SH with addr=0x3001 -> ades=1.
REQ-048 rst asserted mid-BUSY during an SW -> dm_en=0 and req_ready=1 that cycle; no resp_valid afterwards.
REQ-049 With LSU_TIMEOUT_EN defined and TIMEOUT_CYCLES=4, LW with dm_ack never asserted -> bus_err=1 on the resp_valid pulse after 4 BUSY cycles.
REQ-050 Back-to-back LW then SW, with req_valid held through stall -> exactly two bus transactions in order, and stall low only after the second resp_valid.
